// File: rtl/picorv32_axi_mmio_console_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | picorv32_axi_mmio_console_if : AXI4-lite bus bundle for the MMIO window  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface picorv32_axi_mmio_console_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface
`default_nettype wire

// File: rtl/picorv32_axi_mmio_console.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | picorv32_axi_mmio_console : AXI4-lite MMIO slave with console byte FIFO  |
// | and sticky pass/fail status flags.                            Rev 1.0    |
// +--------------------------------------------------------------------------+
module picorv32_axi_mmio_console #(
  parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
  parameter logic [31:0] STATUS_ADDR  = 32'h2000_0000,
  parameter logic [31:0] PASS_MAGIC   = 32'd123456789,
  parameter int          FIFO_AW      = 3
) (
  input  wire logic                        sys_clk,
  input  wire logic                        sys_rst,
  picorv32_axi_mmio_console_if.slave       mem_axi,
  output logic                             console_valid,
  input  wire logic                        console_ready,
  output logic [7:0]                       console_data,
  output logic                             tests_passed,
  output logic                             tests_failed
);

  localparam int unsigned        c_depth       = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   c_depth_cnt   = (FIFO_AW+1)'(c_depth);
  localparam logic [1:0]         c_resp_okay   = 2'b00;
  localparam logic [1:0]         c_resp_slverr = 2'b10;

  localparam logic [1:0] W_COLLECT = 2'd0;
  localparam logic [1:0] W_EXEC    = 2'd1;
  localparam logic [1:0] W_RESP    = 2'd2;
  localparam logic [0:0] R_IDLE    = 1'b0;
  localparam logic [0:0] R_RESP    = 1'b1;

  logic [1:0]         r_wstate;
  logic               r_aw_latched;
  logic               r_w_latched;
  logic [31:0]        r_awaddr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_wstrb;
  logic               r_bvalid;
  logic [1:0]         r_bresp;
  logic               r_passed;
  logic               r_failed;
  logic [0:0]         r_rstate;
  logic [31:0]        r_rdata;
  logic [1:0]         r_rresp;
  logic [7:0]         r_fifo [c_depth];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_is_console;
  logic w_is_status;
  logic w_console_byte;
  logic w_fifo_full;
  logic w_push;
  logic w_pop;
  logic w_exec_stall;

  assign w_aw_hs        = mem_axi.awvalid && mem_axi.awready;
  assign w_w_hs         = mem_axi.wvalid && mem_axi.wready;
  assign w_is_console   = (r_awaddr == CONSOLE_ADDR);
  assign w_is_status    = (r_awaddr == STATUS_ADDR);
  assign w_console_byte = (r_wstate == W_EXEC) && w_is_console && r_wstrb[0];
  // Fullness ignores a simultaneous pop: a pop never makes room in the same cycle.
  assign w_fifo_full    = (r_count == c_depth_cnt);
  assign w_push         = w_console_byte && !w_fifo_full;
  assign w_exec_stall   = w_console_byte && w_fifo_full;
  assign w_pop          = console_valid && console_ready;

  assign mem_axi.awready = (r_wstate == W_COLLECT) && !r_aw_latched;
  assign mem_axi.wready  = (r_wstate == W_COLLECT) && !r_w_latched;
  assign mem_axi.bvalid  = r_bvalid;
  assign mem_axi.bresp   = r_bresp;
  assign mem_axi.arready = (r_rstate == R_IDLE);
  assign mem_axi.rvalid  = (r_rstate == R_RESP);
  assign mem_axi.rdata   = r_rdata;
  assign mem_axi.rresp   = r_rresp;

  assign console_valid = (r_count != '0);
  assign console_data  = r_fifo[r_rd_ptr];
  assign tests_passed  = r_passed;
  assign tests_failed  = r_failed;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_wstate     <= W_COLLECT;
      r_aw_latched <= 1'b0;
      r_w_latched  <= 1'b0;
      r_awaddr     <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_bvalid     <= 1'b0;
      r_bresp      <= c_resp_okay;
      r_passed     <= 1'b0;
      r_failed     <= 1'b0;
    end else begin
      case (r_wstate)
        W_COLLECT: begin
          if (w_aw_hs) r_awaddr <= mem_axi.awaddr;
          if (w_w_hs) begin
            r_wdata <= mem_axi.wdata;
            r_wstrb <= mem_axi.wstrb;
          end
          // Enter execute as soon as both halves are held, whichever arrived last.
          if ((r_aw_latched || w_aw_hs) && (r_w_latched || w_w_hs)) begin
            r_wstate     <= W_EXEC;
            r_aw_latched <= 1'b0;
            r_w_latched  <= 1'b0;
          end else begin
            r_aw_latched <= r_aw_latched || w_aw_hs;
            r_w_latched  <= r_w_latched || w_w_hs;
          end
        end
        W_EXEC: begin
          if (!w_exec_stall) begin
            r_bvalid <= 1'b1;
            r_wstate <= W_RESP;
            r_bresp  <= (w_is_console || w_is_status) ? c_resp_okay : c_resp_slverr;
            if (w_is_status && (r_wstrb == 4'hF)) begin
              if (r_wdata == PASS_MAGIC) r_passed <= 1'b1;
              else                       r_failed <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (mem_axi.bready) begin
            r_bvalid <= 1'b0;
            r_wstate <= W_COLLECT;
          end
        end
        default: r_wstate <= W_COLLECT;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rstate <= R_IDLE;
      r_rdata  <= '0;
      r_rresp  <= c_resp_okay;
    end else if (r_rstate == R_IDLE) begin
      if (mem_axi.arvalid) begin
        r_rstate <= R_RESP;
        if (mem_axi.araddr == STATUS_ADDR) begin
          r_rdata <= {30'b0, r_failed, r_passed};
          r_rresp <= c_resp_okay;
        end else if (mem_axi.araddr == CONSOLE_ADDR) begin
          r_rdata <= 32'(r_count);
          r_rresp <= c_resp_okay;
        end else begin
          r_rdata <= '0;
          r_rresp <= c_resp_slverr;
        end
      end
    end else if (mem_axi.rready) begin
      r_rstate <= R_IDLE;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
        2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= r_wdata[7:0];
  end

endmodule
`default_nettype wire

// File: tb/tb_picorv32_axi_mmio_console.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_picorv32_axi_mmio_console : directed self-checking bench for the MMIO |
// | console/status slave.                                         Rev 1.0    |
// +--------------------------------------------------------------------------+
module tb_picorv32_axi_mmio_console;

  localparam logic [31:0] c_con  = 32'h1000_0000;
  localparam logic [31:0] c_stat = 32'h2000_0000;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       console_ready;
  logic       console_valid;
  logic [7:0] console_data;
  logic       tests_passed;
  logic       tests_failed;
  int         n_pass   = 0;
  int         n_checks = 0;
  int         cyc;

  picorv32_axi_mmio_console_if bus ();

  picorv32_axi_mmio_console dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .mem_axi       (bus),
    .console_valid (console_valid),
    .console_ready (console_ready),
    .console_data  (console_data),
    .tests_passed  (tests_passed),
    .tests_failed  (tests_failed)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic send(input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input bit w_first);
    int n;
    bus.awaddr = addr;
    bus.wdata  = data;
    bus.wstrb  = strb;
    if (w_first) begin
      bus.wvalid = 1'b1;
      n = 0;
      while (!bus.wready && n < 20) begin tick; n++; end
      chk("wready", bus.wready, 1);
      tick;
      bus.wvalid  = 1'b0;
      bus.awvalid = 1'b1;
      n = 0;
      while (!bus.awready && n < 20) begin tick; n++; end
      chk("awready_after_w", bus.awready, 1);
      tick;
      bus.awvalid = 1'b0;
    end else begin
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      n = 0;
      while (!(bus.awready && bus.wready) && n < 20) begin tick; n++; end
      chk("aw_w_ready", {31'b0, bus.awready && bus.wready}, 1);
      tick;
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
    end
  endtask

  task automatic wait_b(input int max, output int c);
    c = 0;
    while (!bus.bvalid && c < max) begin tick; c++; end
  endtask

  task automatic b_ack;
    bus.bready = 1'b1;
    tick;
    bus.bready = 1'b0;
  endtask

  // Full write with same-cycle or W-first issue; response left pending for the caller.
  task automatic write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                       input bit w_first, input string tag, input logic [1:0] exp_resp);
    int c;
    send(addr, data, strb, w_first);
    wait_b(10, c);
    chk({tag, "_bvalid"}, bus.bvalid, 1);
    chk({tag, "_lat"}, c, 1);
    chk({tag, "_bresp"}, bus.bresp, exp_resp);
  endtask

  task automatic read(input logic [31:0] addr, input string tag,
                      input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int n;
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 20) begin tick; n++; end
    chk({tag, "_arready"}, bus.arready, 1);
    tick;
    bus.arvalid = 1'b0;
    chk({tag, "_rvalid"}, bus.rvalid, 1);
    chk({tag, "_rdata"}, bus.rdata, exp_data);
    chk({tag, "_rresp"}, bus.rresp, exp_resp);
    bus.rready = 1'b1;
    tick;
    bus.rready = 1'b0;
    chk({tag, "_rvalid_done"}, bus.rvalid, 0);
  endtask

  initial begin
    bus.awvalid = 1'b0; bus.awaddr = '0; bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.bready  = 1'b0; bus.arvalid = 1'b0; bus.araddr = '0; bus.rready = 1'b0;
    console_ready = 1'b0;
    sys_rst = 1'b1;
    tick;
    tick;
    sys_rst = 1'b0;

    // Reset state
    chk("rst_awready", bus.awready, 1);
    chk("rst_wready", bus.wready, 1);
    chk("rst_arready", bus.arready, 1);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_bresp", bus.bresp, 0);
    chk("rst_rresp", bus.rresp, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_cvalid", console_valid, 0);
    chk("rst_pass", tests_passed, 0);
    chk("rst_fail", tests_failed, 0);

    // Console bytes stream out in order with a ready consumer
    console_ready = 1'b1;
    write(c_con, 32'h0000_0041, 4'hF, 1'b0, "con41", 2'b00);
    chk("con41_valid", console_valid, 1);
    chk("con41_data", console_data, 8'h41);
    b_ack;
    chk("con41_drained", console_valid, 0);
    write(c_con, 32'hABCD_0042, 4'h1, 1'b0, "con42", 2'b00);
    chk("con42_valid", console_valid, 1);
    chk("con42_data", console_data, 8'h42);
    b_ack;
    chk("con42_drained", console_valid, 0);
    write(c_con, 32'h0000_0077, 4'hE, 1'b0, "nostrb", 2'b00);
    b_ack;
    chk("nostrb_cvalid", console_valid, 0);

    // Fill the FIFO with the consumer stalled
    console_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      write(c_con, 32'h10 + i, 4'h1, 1'b0, "fill", 2'b00);
      b_ack;
    end
    read(c_con, "occ_full", 32'd8, 2'b00);
    send(c_con, 32'h18, 4'h1, 1'b0);
    wait_b(5, cyc);
    chk("ninth_stall", bus.bvalid, 0);
    chk("ninth_awready", bus.awready, 0);
    chk("head_10", console_data, 8'h10);
    console_ready = 1'b1;
    tick;
    console_ready = 1'b0;
    wait_b(10, cyc);
    chk("ninth_bvalid", bus.bvalid, 1);
    chk("ninth_bresp", bus.bresp, 0);
    b_ack;
    chk("head_11", console_data, 8'h11);
    read(c_con, "occ_refill", 32'd8, 2'b00);

    // Status flags: partial strobe ignored, pass then fail both stick
    write(c_stat, 32'd123456789, 4'h7, 1'b0, "stat_part", 2'b00);
    b_ack;
    chk("part_pass", tests_passed, 0);
    chk("part_fail", tests_failed, 0);
    write(c_stat, 32'd123456789, 4'hF, 1'b1, "stat_pass", 2'b00);
    b_ack;
    chk("pass_set", tests_passed, 1);
    chk("pass_nofail", tests_failed, 0);
    read(c_stat, "stat_rd1", 32'h1, 2'b00);
    write(c_stat, 32'd5, 4'hF, 1'b0, "stat_fail", 2'b00);
    b_ack;
    chk("fail_set", tests_failed, 1);
    chk("fail_pass_kept", tests_passed, 1);
    read(c_stat, "stat_rd3", 32'h3, 2'b00);

    // Unmapped write: SLVERR held while bready is low, no side effects
    send(32'h3000_0000, 32'h0000_00AA, 4'hF, 1'b0);
    wait_b(10, cyc);
    chk("err_bvalid", bus.bvalid, 1);
    for (int k = 0; k < 4; k++) begin
      chk("err_bvalid_hold", bus.bvalid, 1);
      chk("err_bresp_hold", bus.bresp, 2'b10);
      tick;
    end
    b_ack;
    chk("err_bvalid_done", bus.bvalid, 0);
    chk("err_head", console_data, 8'h11);
    read(c_con, "err_occ", 32'd8, 2'b00);

    // Unmapped read: SLVERR, zero data, held while rready is low
    bus.araddr  = 32'h0;
    bus.arvalid = 1'b1;
    tick;
    bus.arvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("rerr_rvalid", bus.rvalid, 1);
      chk("rerr_rdata", bus.rdata, 0);
      chk("rerr_rresp", bus.rresp, 2'b10);
      chk("rerr_arready", bus.arready, 0);
      tick;
    end
    bus.rready = 1'b1;
    tick;
    bus.rready = 1'b0;
    chk("rerr_done", bus.rvalid, 0);

    // Reset while stalled in execute with a full FIFO
    send(c_con, 32'h99, 4'h1, 1'b0);
    tick;
    chk("t6_stall", bus.bvalid, 0);
    sys_rst = 1'b1;
    tick;
    tick;
    sys_rst = 1'b0;
    chk("t6_cvalid", console_valid, 0);
    chk("t6_bvalid", bus.bvalid, 0);
    chk("t6_pass", tests_passed, 0);
    chk("t6_fail", tests_failed, 0);
    chk("t6_awready", bus.awready, 1);
    tick;
    tick;
    tick;
    chk("t6_no_resp", bus.bvalid, 0);
    read(c_con, "t6_occ", 32'd0, 2'b00);
    write(c_con, 32'h5A, 4'h1, 1'b0, "t6_con", 2'b00);
    chk("t6_data", console_data, 8'h5A);
    b_ack;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
